text_mode_ctrl: RTL and testbench

//  Text-mode sequencer in front of the 8x8 font ROM. Holds a COLS x ROWS character

---
 rtl/text_mode_ctrl.sv | 127 ++++++++++++
 tb/tb_text_mode_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/text_mode_ctrl.sv
// text_mode_ctrl: character-buffer sequencer feeding the 8x8 font ROM, with host writes, clear engine and cursor overlay.
// Optional cursor blink is enabled by defining CURSOR_BLINK_EN.
module text_mode_ctrl #(
    parameter int         COLS         = 80,
    parameter int         ROWS         = 30,
    parameter logic [7:0] CLEAR_CHAR   = 8'h20,
    parameter int         BLINK_FRAMES = 30
) (
    input  logic       px_clk,
    input  logic       reset_n,
    input  logic [9:0] pos_x,
    input  logic [9:0] pos_y,
    input  logic       frame_start,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [6:0] wr_col,
    input  logic [4:0] wr_row,
    input  logic [7:0] wr_char,
    input  logic       clr_req,
    output logic       busy,
    input  logic [6:0] cur_col,
    input  logic [4:0] cur_row,
    input  logic       cursor_on,
    output logic [7:0] character,
    output logic [9:0] font_x,
    output logic [9:0] font_y,
    output logic       cursor_inv
);
    localparam int          CELLS = COLS * ROWS;
    localparam logic [7:0]  NCOL  = 8'(COLS);
    localparam logic [5:0]  NROW  = 6'(ROWS);
    localparam logic [11:0] NCOLW = 12'(COLS);
    localparam logic [11:0] LAST  = 12'(CELLS - 1);

    typedef enum logic {CLEAR, IDLE} state_t;

    state_t      state;
    logic [11:0] clr_cnt;
    logic [7:0]  mem [CELLS];
    logic [6:0]  col;
    logic [4:0]  row;
    logic        rd_ok, wr_ok, hit, hit_d, blink_phase;
    logic        we;
    logic [11:0] rd_addr, wr_addr, wa;
    logic [7:0]  wd;

    assign col     = pos_x[9:3];
    assign row     = pos_y[7:3];
    assign rd_ok   = ({1'b0, col} < NCOL) && ({1'b0, row} < NROW);
    assign wr_ok   = ({1'b0, wr_col} < NCOL) && ({1'b0, wr_row} < NROW);
    assign rd_addr = 12'(row) * NCOLW + 12'(col);
    assign wr_addr = 12'(wr_row) * NCOLW + 12'(wr_col);
    assign hit     = cursor_on & rd_ok & (col == cur_col) & (row == cur_row) & blink_phase;

    // The clear engine owns the single write port while it runs; host writes are only accepted in IDLE.
    assign we = (state == CLEAR) | (wr_valid & wr_ready & wr_ok);
    assign wa = (state == CLEAR) ? clr_cnt : wr_addr;
    assign wd = (state == CLEAR) ? CLEAR_CHAR : wr_char;

    always_ff @(posedge px_clk) begin
        if (we)
            mem[wa] <= wd;
    end

    always_ff @(posedge px_clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= CLEAR;
            clr_cnt  <= '0;
            busy     <= 1'b1;
            wr_ready <= 1'b0;
        end else if (state == CLEAR) begin
            if (clr_cnt == LAST) begin
                state    <= IDLE;
                clr_cnt  <= '0;
                busy     <= 1'b0;
                wr_ready <= 1'b1;
            end else begin
                clr_cnt <= clr_cnt + 12'd1;
            end
        end else if (clr_req) begin
            state    <= CLEAR;
            busy     <= 1'b1;
            wr_ready <= 1'b0;
        end
    end

    always_ff @(posedge px_clk or negedge reset_n) begin
        if (!reset_n) begin
            character  <= '0;
            font_x     <= '0;
            font_y     <= '0;
            hit_d      <= 1'b0;
            cursor_inv <= 1'b0;
        end else begin
            character  <= rd_ok ? mem[rd_ok ? rd_addr : 12'd0] : 8'h00;
            font_x     <= pos_x;
            font_y     <= pos_y;
            hit_d      <= hit;
            cursor_inv <= hit_d;
        end
    end

`ifdef CURSOR_BLINK_EN
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [FW-1:0] frame_cnt;

    always_ff @(posedge px_clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_cnt   <= '0;
            blink_phase <= 1'b1;
        end else if (frame_start) begin
            if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
                frame_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end
`else
    logic unused_frame;

    assign blink_phase  = 1'b1;
    assign unused_frame = frame_start;
`endif
endmodule

// File: tb/tb_text_mode_ctrl.sv
// tb_text_mode_ctrl: directed + randomized bench for text_mode_ctrl against a cell-array reference model.
// Blink expectations follow CURSOR_BLINK_EN when it is defined for the build.
module tb_text_mode_ctrl;
    localparam int COLS  = 80;
    localparam int ROWS  = 30;
    localparam int BLINK = 30;

    logic       px_clk = 1'b0;
    logic       reset_n;
    logic [9:0] pos_x, pos_y;
    logic       frame_start, wr_valid, wr_ready, clr_req, busy, cursor_on, cursor_inv;
    logic [6:0] wr_col, cur_col;
    logic [4:0] wr_row, cur_row;
    logic [7:0] wr_char, character;
    logic [9:0] font_x, font_y;

    int passed = 0;
    int total  = 0;
    int fails  = 0;
    int frames = 0;
    logic [7:0] mm [COLS*ROWS];

    text_mode_ctrl dut (
        .px_clk(px_clk), .reset_n(reset_n), .pos_x(pos_x), .pos_y(pos_y),
        .frame_start(frame_start), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_col(wr_col), .wr_row(wr_row), .wr_char(wr_char), .clr_req(clr_req),
        .busy(busy), .cur_col(cur_col), .cur_row(cur_row), .cursor_on(cursor_on),
        .character(character), .font_x(font_x), .font_y(font_y), .cursor_inv(cursor_inv)
    );

    always #5 px_clk = ~px_clk;

    task automatic tick();
        @(posedge px_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit phase();
`ifdef CURSOR_BLINK_EN
        return ((frames / BLINK) % 2) == 0;
`else
        return 1'b1;
`endif
    endfunction

    function automatic logic [7:0] exp_char(input int px, input int py);
        int c = (px / 8) % 128;
        int r = (py / 8) % 32;
        return (c < COLS && r < ROWS) ? mm[r*COLS + c] : 8'h00;
    endfunction

    function automatic logic exp_inv(input int px, input int py);
        int c = (px / 8) % 128;
        int r = (py / 8) % 32;
        return cursor_on && c == int'(cur_col) && r == int'(cur_row) && c < COLS && r < ROWS && phase();
    endfunction

    // The position moves off-screen after one cycle, so cursor_inv must come from exactly t+2.
    task automatic rd(input string tag, input int px, input int py);
        logic [7:0] ec = exp_char(px, py);
        logic       ei = exp_inv(px, py);
        pos_x = 10'(px);
        pos_y = 10'(py);
        tick();
        chk({tag, "_char"}, 32'(character), 32'(ec));
        chk({tag, "_fx"}, 32'(font_x), 32'(px));
        chk({tag, "_fy"}, 32'(font_y), 32'(py));
        pos_x = 10'd1023;
        pos_y = 10'd1023;
        tick();
        chk({tag, "_inv"}, 32'(cursor_inv), 32'(ei));
    endtask

    task automatic wr(input int c, input int r, input logic [7:0] ch, input logic clr);
        wr_valid = 1'b1;
        wr_col   = 7'(c);
        wr_row   = 5'(r);
        wr_char  = ch;
        clr_req  = clr;
        chk("wr_ready_idle", 32'(wr_ready), 32'd1);
        tick();
        if (c < COLS && r < ROWS) mm[r*COLS + c] = ch;
        wr_valid = 1'b0;
        clr_req  = 1'b0;
    endtask

    task automatic wait_clear(input string tag);
        int n = 0;
        while (busy && n < 5000) begin
            tick();
            n++;
        end
        chk(tag, 32'(n), 32'd2400);
        chk({tag, "_ready"}, 32'(wr_ready), 32'd1);
        foreach (mm[i]) mm[i] = 8'h20;
    endtask

    initial begin
        reset_n = 1'b0; pos_x = '0; pos_y = '0; frame_start = 1'b0; wr_valid = 1'b0;
        wr_col = '0; wr_row = '0; wr_char = '0; clr_req = 1'b0;
        cur_col = '0; cur_row = '0; cursor_on = 1'b0;
        repeat (3) tick();
        chk("rst_char", 32'(character), 32'd0);
        chk("rst_fx", 32'(font_x), 32'd0);
        chk("rst_fy", 32'(font_y), 32'd0);
        chk("rst_inv", 32'(cursor_inv), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_ready", 32'(wr_ready), 32'd0);

        // Abort a clear part-way with reset; it must restart from cell 0.
        reset_n = 1'b1;
        repeat (500) tick();
        chk("mid_busy", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd1);
        chk("mid_rst_ready", 32'(wr_ready), 32'd0);
        chk("mid_rst_char", 32'(character), 32'd0);
        repeat (2) tick();
        reset_n = 1'b1;
        wait_clear("clear_len");

        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                rd("sweep", c*8 + int'($urandom_range(0, 7)), r*8 + int'($urandom_range(0, 7)));

        wr(5, 2, 8'h41, 1'b0);
        pos_x = 10'd40;
        pos_y = 10'd16;
        tick();
        chk("t2_char", 32'(character), 32'h41);
        chk("t2_fx", 32'(font_x), 32'd40);
        chk("t2_fy", 32'(font_y), 32'd16);

        cursor_on = 1'b1;
        cur_col = 7'd80;
        cur_row = 5'd2;
        rd("t3_col80", 640, 16);
        chk("t3_direct", 32'(exp_char(640, 16)), 32'd0);

        repeat (80) begin
            int c = int'($urandom_range(0, 90));
            int r = int'($urandom_range(0, 31));
            wr(c, r, 8'($urandom), 1'b0);
            cursor_on = 1'($urandom);
            cur_col = 7'(c + int'($urandom_range(0, 1)));
            cur_row = 5'(r);
            rd("rnd_hit", c*8 + int'($urandom_range(0, 7)), r*8 + int'($urandom_range(0, 7)));
            rd("rnd_any", int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)));
        end

        wr(7, 3, 8'h55, 1'b1);
        chk("t4_busy", 32'(busy), 32'd1);
        chk("t4_ready", 32'(wr_ready), 32'd0);
        begin
            int n = 0;
            while (busy && n < 5000) begin
                clr_req  = (n == 1000);
                wr_valid = (n >= 1000 && n < 2000);
                wr_col   = 7'd9;
                wr_row   = 5'd9;
                wr_char  = 8'h99;
                if (n == 1000 || n == 1500) chk("t4_no_ready", 32'(wr_ready), 32'd0);
                tick();
                n++;
            end
            wr_valid = 1'b0;
            clr_req  = 1'b0;
            chk("t4_clear_len", 32'(n), 32'd2400);
            foreach (mm[i]) mm[i] = 8'h20;
        end
        rd("t4_cell73", 56, 24);
        rd("t4_cell99", 72, 72);
        rd("t4_cell52", 40, 16);

        cursor_on = 1'b1;
        cur_col = 7'd3;
        cur_row = 5'd1;
        rd("t5_hit", 24, 8);
        rd("t5_right", 32, 8);
        rd("t5_below", 24, 16);
        rd("t5_left", 23, 15);

        for (int k = 0; k < 2; k++) begin
            repeat (BLINK) begin
                frame_start = 1'b1;
                tick();
                frame_start = 1'b0;
                frames++;
                tick();
            end
            rd("t6_blink", 27, 12);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
